uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Transmit-side byte buffer and launch sequencer sitting directly upstream of the UART transmitter. It accepts bytes from a host write port and stores them in a FIFO. It drives the UART's start/tx_data_in pair one byte at a time, pacing on done_tx/tx_active. It also reports occupancy, overflow and a stuck-transmitter timeout.

Parameters:
DATA_WIDTH, 8, byte width; must match the UART.
DEPTH, 16, FIFO entries; power of two, at least 2.
TIMEOUT_CYCLES, 65536, max clocks from start pulse to done_tx before the frame is abandoned (one 8N1 frame at 50 MHz / 19200 baud is about 26042 clocks).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
wr_en  in  1  host write strobe
wr_data  in  DATA_WIDTH  host byte
flush  in  1  synchronous FIFO clear
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: a write was dropped
timeout_err  out  1  sticky: done_tx missing within TIMEOUT_CYCLES
busy  out  1  a frame is in flight (FSM not in IDLE)
start  out  1  one-cycle launch pulse to UART
tx_data_in  out  DATA_WIDTH  byte to UART; registered, held stable through the frame
done_tx  in  1  UART frame-complete pulse
tx_active  in  1  UART transmitter busy

Behaviour:
- Reset (rst=0, async): FIFO pointers and count cleared. empty=1, full=0, count=0. overflow=0, timeout_err=0, start=0, tx_data_in=0, busy=0. FSM enters IDLE. This takes effect mid-frame as well; the UART is not notified.
- FIFO write: accepted when wr_en=1 and full=0, judged on the registered full at that edge. A write while full is dropped and sets overflow, even if a pop occurs in the same cycle.
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. full/empty are derived from count, with no off-by-one at DEPTH.
- First-word latency: a byte written into an empty FIFO can be popped no earlier than the next cycle.
- flush=1: on that edge count, pointers and overflow are cleared. A same-cycle write is discarded and does not set overflow. The in-flight frame is not aborted; the FSM is unaffected. timeout_err is cleared only by reset.
- FSM states:
  - IDLE: if empty=0 and tx_active=0, pop the head into tx_data_in, assert start for exactly 1 cycle, clear the timer, go to WAIT_DONE. Otherwise stay.
  - WAIT_DONE: the timer increments each cycle.
    - done_tx=1: go to GAP.
    - Timer reaches TIMEOUT_CYCLES-1 without done_tx: set timeout_err, go to GAP.
  - GAP: 1 cycle, so the UART deasserts done_tx before the next launch; then IDLE.
- done_tx seen in IDLE or GAP is ignored.
- busy=1 in WAIT_DONE and GAP.
- Back-to-back throughput: consecutive start pulses are separated by frame time plus 2 cycles (done, GAP, IDLE-launch).
- tx_data_in changes only on a pop; it holds its last value otherwise.
- flush during WAIT_DONE: the current byte finishes; the FIFO is empty afterward, so no further launch.

Decomposition:
- uart_pkg gains: typedef enum logic [1:0] {TXF_IDLE, TXF_WAIT_DONE, TXF_GAP} txf_state_t, and a localparam UART_DATA_WIDTH = 8 for the default.
- Sub-module sync_fifo holds the storage:
  - Parameters: DATA_WIDTH, DEPTH.
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, flush, full, empty, count.
  - Read data is registered on rd_en.
- uart_tx_fifo holds the FSM, timer, sticky flags and output registers.

Test Plan:
1. Reset then idle: after rst release with no writes -> empty=1, count=0, start never asserts over 1000 cycles, tx_data_in=0x00.
2. Single byte, loopback UART at 19200 baud: write 0xA5 -> start pulses once (1 cycle), tx_data_in=0xA5, busy=1 until 2 cycles after done_tx, UART rx_data_out=0xA5.
3. Burst ordering: write 0x01..0x05 on consecutive cycles -> count peaks at 4 or 5, UART receives 0x01,0x02,0x03,0x04,0x05 in order, exactly 5 start pulses, empty=1 at end.
4. Overflow, DEPTH=16, UART held in reset: write 17 bytes 0x10..0x20 -> full=1 after the 16th write, overflow=1, count=16. After UART release, 0x10..0x1F are transmitted and 0x20 never appears.
5. Timeout, TIMEOUT_CYCLES=100, done_tx tied 0: write 0x3C -> start pulse, then timeout_err=1 exactly 100 cycles after start, FSM returns to IDLE. A next byte 0x3D launches; timeout_err stays 1 until reset.
6. Flush and reset mid-frame: queue 0x11,0x22,0x33, then flush during the first frame -> 0x11 completes, 0x22/0x33 never sent, count=0. Repeat with rst=0 mid-frame -> all outputs return to reset values immediately (asynchronous).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Holds the launch-sequencer state encoding and width defaults.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    TXF_IDLE,
    TXF_WAIT_DONE,
    TXF_GAP
  } txf_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-derived full/empty and registered read data.
// Flush clears pointers and count but leaves the last read byte in place.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_ok, rd_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = rd_data_q;

  // Flush discards a same-cycle write.
  assign wr_ok = wr_en & ~full & ~flush;
  assign rd_ok = rd_en & ~empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (rd_ok) begin
      rd_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + AW'(1);
    end
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    unique case (1'b1)
      flush: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
      (wr_ok && !rd_ok): count_d = count_q + CW'(1);
      (rd_ok && !wr_ok): count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer plus launch sequencer feeding the UART transmitter.
// Paces launches on done_tx/tx_active and flags overflow and stuck frames.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       timeout_err,
  output logic                       busy,
  output logic                       start,
  output logic [DATA_WIDTH-1:0]      tx_data_in,
  input  logic                       done_tx,
  input  logic                       tx_active
);

  localparam int TW = $clog2(TIMEOUT_CYCLES+1);

  txf_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic start_q, start_d;
  logic overflow_q, overflow_d;
  logic timeout_q, timeout_d;
  logic pop;

  // The FIFO read register doubles as the held UART data byte.
  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_en  (pop),
    .rd_data(tx_data_in),
    .flush  (flush),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    start_d    = 1'b0;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    pop        = 1'b0;
    unique case (1'b1)
      flush:          overflow_d = 1'b0;
      (wr_en & full): overflow_d = 1'b1;
      default:        overflow_d = overflow_q;
    endcase
    unique case (state_q)
      TXF_IDLE: begin
        if (!empty && !tx_active) begin
          pop     = 1'b1;
          start_d = 1'b1;
          timer_d = '0;
          state_d = TXF_WAIT_DONE;
        end
      end
      TXF_WAIT_DONE: begin
        timer_d = timer_q + TW'(1);
        if (done_tx) begin
          state_d = TXF_GAP;
        end else if (timer_q == TW'(TIMEOUT_CYCLES-1)) begin
          timeout_d = 1'b1;
          state_d   = TXF_GAP;
        end
      end
      TXF_GAP: state_d = TXF_IDLE;
      default: state_d = TXF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= TXF_IDLE;
      timer_q    <= '0;
      start_q    <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      start_q    <= start_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign start       = start_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;
  assign busy        = (state_q != TXF_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with a behavioural UART and a byte scoreboard.
// Vector tables cover FIFO fill/flush; sequences cover frame timing.
module tb_uart_tx_fifo;

  localparam int FRAME = 40;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       timeout_err;
  logic       busy;
  logic       start;
  logic [7:0] tx_data_in;
  logic       done_tx;
  logic       tx_active;

  logic       in_frame;
  logic       uart_hold;
  logic       done_dis;
  logic [7:0] shreg;
  int         fcnt;
  int         cyc;
  int         nstart;
  int         last_start;
  int         checks;
  int         failures;
  logic [7:0] expq [$];
  logic [7:0] rxq [$];

  typedef struct {
    bit         wr;
    bit         fl;
    logic [7:0] d;
    bit         push;
    logic [4:0] cnt;
    bit         full;
    bit         empty;
    bit         ov;
  } vec_t;

  vec_t va [$];
  vec_t vb [$];

  assign tx_active = in_frame | uart_hold;

  uart_tx_fifo #(
    .DATA_WIDTH    (8),
    .DEPTH         (16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .flush      (flush),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .timeout_err(timeout_err),
    .busy       (busy),
    .start      (start),
    .tx_data_in (tx_data_in),
    .done_tx    (done_tx),
    .tx_active  (tx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // One clock; sample at the falling edge, then advance the UART model.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    done_tx = 1'b0;
    if (start) begin
      nstart++;
      last_start = cyc;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_start got=%0h want=none",
                 tx_data_in);
      end else begin
        chk("start_data", tx_data_in, expq.pop_front());
      end
      in_frame = 1'b1;
      fcnt     = 0;
      shreg    = tx_data_in;
    end else if (in_frame) begin
      fcnt++;
      if (fcnt == FRAME) begin
        in_frame = 1'b0;
        if (!done_dis) begin
          done_tx = 1'b1;
          rxq.push_back(shreg);
        end
      end
    end
  endtask

  task automatic wr(input logic [7:0] d, input bit push);
    wr_en   = 1'b1;
    wr_data = d;
    if (push) expq.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((expq.size() != 0 || busy || in_frame || !empty)
           && n < 5000) begin
      tick();
      n++;
    end
    chk(nm, 32'(n < 5000), 1);
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    int s0 = nstart;
    while (nstart == s0 && n < 200) begin
      tick();
      n++;
    end
    chk(nm, 32'(nstart != s0), 1);
  endtask

  task automatic run_vecs(input string nm, input vec_t v [$]);
    foreach (v[i]) begin
      wr_en   = v[i].wr;
      flush   = v[i].fl;
      wr_data = v[i].d;
      if (v[i].push) expq.push_back(v[i].d);
      tick();
      wr_en = 1'b0;
      flush = 1'b0;
      chk($sformatf("%s_row%0d", nm, i),
          {count, full, empty, overflow},
          {v[i].cnt, v[i].full, v[i].empty, v[i].ov});
    end
  endtask

  initial begin
    int peak;
    int s0;
    int t;
    int n;
    checks = 0;
    failures = 0;
    cyc = 0;
    nstart = 0;
    last_start = 0;
    rst = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    flush = 1'b0;
    done_tx = 1'b0;
    in_frame = 1'b0;
    uart_hold = 1'b0;
    done_dis = 1'b0;
    fcnt = 0;
    shreg = '0;

    for (int i = 0; i < 17; i++) begin
      va.push_back('{1'b1, 1'b0, 8'(8'h10 + i), (i < 16),
                     5'((i < 16) ? i + 1 : 16),
                     (i >= 15), 1'b0, (i == 16)});
    end
    vb.push_back('{1, 0, 8'h50, 0, 5'd1, 0, 0, 1});
    vb.push_back('{1, 0, 8'h51, 0, 5'd2, 0, 0, 1});
    vb.push_back('{1, 1, 8'h52, 0, 5'd0, 0, 1, 0});
    vb.push_back('{1, 0, 8'h53, 0, 5'd1, 0, 0, 0});
    vb.push_back('{0, 1, 8'h00, 0, 5'd0, 0, 1, 0});

    // Reset and idle
    tick();
    tick();
    chk("rst_vals",
        {count, full, empty, overflow, timeout_err, busy, start},
        {5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("rst_txd", tx_data_in, 8'h00);
    rst = 1'b1;
    repeat (1000) tick();
    chk("idle_starts", nstart, 0);
    chk("idle_empty", {empty, count}, {1'b1, 5'd0});
    chk("idle_txd", tx_data_in, 8'h00);

    // Single byte
    rxq.delete();
    wr(8'hA5, 1);
    wait_start("single_start");
    tick();
    chk("single_pulse", start, 0);
    chk("single_txd_hold", tx_data_in, 8'hA5);
    n = 0;
    while (!done_tx && n < 200) begin
      tick();
      n++;
    end
    chk("single_done", done_tx, 1);
    chk("single_busy_d0", busy, 1);
    tick();
    chk("single_busy_d1", busy, 1);
    tick();
    chk("single_busy_d2", busy, 0);
    chk("single_rx", (rxq.size() == 1) ? rxq[0] : 8'hxx, 8'hA5);

    // Burst ordering
    rxq.delete();
    s0 = nstart;
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      wr(8'(i), 1);
      if (int'(count) > peak) peak = int'(count);
    end
    chk("burst_peak", 32'(peak == 4 || peak == 5), 1);
    drain("burst_drain");
    chk("burst_starts", nstart - s0, 5);
    chk("burst_rxn", rxq.size(), 5);
    for (int i = 0; i < 5 && i < rxq.size(); i++) begin
      chk($sformatf("burst_rx%0d", i), rxq[i], 8'(i + 1));
    end
    chk("burst_empty", empty, 1);

    // Overflow with the UART held busy
    rxq.delete();
    uart_hold = 1'b1;
    run_vecs("ovf", va);
    uart_hold = 1'b0;
    drain("ovf_drain");
    chk("ovf_rxn", rxq.size(), 16);
    for (int i = 0; i < 16 && i < rxq.size(); i++) begin
      chk($sformatf("ovf_rx%0d", i), rxq[i], 8'(8'h10 + i));
    end
    chk("ovf_sticky", overflow, 1);

    // Simultaneous write and pop keeps the count
    uart_hold = 1'b1;
    wr(8'h60, 1);
    wr(8'h61, 1);
    chk("simul_pre", count, 2);
    uart_hold = 1'b0;
    wr(8'h62, 1);
    chk("simul_cnt", count, 2);
    chk("simul_start", start, 1);
    drain("simul_drain");

    // Flush table with the UART held busy
    uart_hold = 1'b1;
    run_vecs("flush", vb);
    uart_hold = 1'b0;
    s0 = nstart;
    repeat (60) tick();
    chk("flush_nostart", nstart - s0, 0);

    // Timeout
    done_dis = 1'b1;
    chk("to_pre", timeout_err, 0);
    wr(8'h3C, 1);
    wait_start("to_start");
    s0 = last_start;
    n = 0;
    while (!timeout_err && n < 300) begin
      tick();
      n++;
    end
    t = cyc;
    chk("to_latency", t - s0, 100);
    chk("to_gap_busy", busy, 1);
    tick();
    chk("to_idle", busy, 0);
    done_dis = 1'b0;
    wr(8'h3D, 1);
    wait_start("to_next_start");
    drain("to_drain");
    chk("to_sticky", timeout_err, 1);

    // Flush mid-frame
    rxq.delete();
    s0 = nstart;
    wr(8'h11, 1);
    wr(8'h22, 1);
    wr(8'h33, 1);
    repeat (5) tick();
    flush = 1'b1;
    expq.delete();
    tick();
    flush = 1'b0;
    chk("mflush_cnt", count, 0);
    chk("mflush_busy", busy, 1);
    drain("mflush_drain");
    repeat (60) tick();
    chk("mflush_starts", nstart - s0, 1);
    chk("mflush_rx", (rxq.size() == 1) ? rxq[0] : 8'hxx, 8'h11);

    // Asynchronous reset mid-frame
    wr(8'h44, 1);
    wr(8'h45, 1);
    wait_start("mrst_start");
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("mrst_vals",
        {count, full, empty, overflow, timeout_err, busy, start},
        {5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("mrst_txd", tx_data_in, 8'h00);
    in_frame = 1'b0;
    expq.delete();
    tick();
    rst = 1'b1;
    s0 = nstart;
    repeat (100) tick();
    chk("mrst_quiet", nstart - s0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
